// File: rtl/rom_scanner.sv
// Address sequencer sweeping START_ADDR..END_ADDR of a combinational ROM, with a valid/ready word output.
// Optional build macro ROM_SCAN_HALT_ON_ERR_EN: an illegal capture parks the scanner in ERROR until rst.
module rom_scanner #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 255,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DIV        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_mode,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  input  logic              i_rom_illegal,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [2:0]        o_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  // Output handshake: o_data is transferred on a clk edge where o_valid && i_ready;
  // once raised, o_valid and o_data hold unchanged until that transfer (or rst).

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W:0]  next_addr;
  logic             past_end;

  // One extra bit so a step past the top of the address space is still seen as "past END_ADDR".
  assign next_addr = {1'b0, o_addr} + (ADDR_W+1)'(STEP);
  assign past_end  = next_addr > (ADDR_W+1)'(END_ADDR);

  assign o_busy  = (state == FETCH) || (state == HOLD);
  assign o_done  = (state == DONE);
  assign o_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      o_addr  <= ADDR_W'(START_ADDR);
      o_data  <= '0;
      o_valid <= 1'b0;
      o_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_start) o_error <= 1'b0;
          if (i_enable && !i_mode) begin
            state <= FETCH;
          end else if (i_enable && i_mode && i_start) begin
            state  <= FETCH;
            o_addr <= ADDR_W'(START_ADDR);
          end
        end
        FETCH: begin
          if (!i_enable) begin
            // o_addr is kept so a later enable resumes at the same word.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef ROM_SCAN_HALT_ON_ERR_EN
            if (i_rom_illegal) begin
              state   <= ERROR;
              o_error <= 1'b1;
            end else begin
              o_data  <= i_rom_data;
              o_valid <= 1'b1;
              state   <= HOLD;
            end
`else
            o_data  <= i_rom_data;
            o_valid <= 1'b1;
            state   <= HOLD;
            if (i_rom_illegal) o_error <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            if (past_end && i_mode) begin
              state <= DONE;
            end else begin
              o_addr <= past_end ? ADDR_W'(START_ADDR) : next_addr[ADDR_W-1:0];
              state  <= i_enable ? FETCH : IDLE;
            end
          end
        end
        DONE: begin
          if (i_start && i_enable) begin
            state   <= FETCH;
            o_addr  <= ADDR_W'(START_ADDR);
            o_error <= 1'b0;
          end else if (!i_mode) begin
            state <= IDLE;
          end
        end
        ERROR: state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scanner.sv
// Bench for rom_scanner: a default-parameter instance (a) and a stride/prescaler instance (b),
// checked against an arithmetic model of the sweep and a ROM content function.
module tb_rom_scanner;

  localparam int unsigned B_START = 2;
  localparam int unsigned B_END   = 20;
  localparam int unsigned B_STEP  = 3;
  localparam int unsigned B_DIV   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable_a, mode_a, start_a, ready_a, valid_a, busy_a, done_a, error_a, ill_a;
  logic [31:0] addr_a, ill_addr_a;
  logic [7:0]  data_a, rom_a;
  logic [2:0]  state_a;
  logic        enable_b, mode_b, start_b, ready_b, valid_b, busy_b, done_b, error_b, ill_b;
  logic [31:0] addr_b;
  logic [7:0]  data_b, rom_b;
  logic [2:0]  state_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  function automatic logic [7:0] rom_f(input logic [31:0] a);
    return ((a[7:0] * 8'd37) + 8'h5A) ^ {a[3:0], a[7:4]};
  endfunction

  assign rom_a = rom_f(addr_a);
  assign ill_a = (addr_a == ill_addr_a);
  assign rom_b = rom_f(addr_b);
  assign ill_b = 1'b0;

  rom_scanner dut_a (
    .clk(clk), .rst(rst), .i_enable(enable_a), .i_mode(mode_a), .i_start(start_a),
    .o_addr(addr_a), .i_rom_data(rom_a), .i_rom_illegal(ill_a), .o_data(data_a),
    .o_valid(valid_a), .i_ready(ready_a), .o_busy(busy_a), .o_done(done_a),
    .o_error(error_a), .o_state(state_a)
  );

  rom_scanner #(.START_ADDR(B_START), .END_ADDR(B_END), .STEP(B_STEP), .DIV(B_DIV)) dut_b (
    .clk(clk), .rst(rst), .i_enable(enable_b), .i_mode(mode_b), .i_start(start_b),
    .o_addr(addr_b), .i_rom_data(rom_b), .i_rom_illegal(ill_b), .o_data(data_b),
    .o_valid(valid_b), .i_ready(ready_b), .o_busy(busy_b), .o_done(done_b),
    .o_error(error_b), .o_state(state_b)
  );

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    enable_a = 1'b0; mode_a = 1'b0; start_a = 1'b0; ready_a = 1'b1;
    enable_b = 1'b0; mode_b = 1'b0; start_b = 1'b0; ready_b = 1'b1;
    ill_addr_a = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid_a(input int budget, output int n, output bit found);
    n = 0; found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); n++;
      if (valid_a) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_valid_b(input int budget, output int n, output bit found);
    n = 0; found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); n++;
      if (valid_b) begin found = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if (addr_a !== 32'd0 || data_a !== 8'd0 || valid_a !== 1'b0 || busy_a !== 1'b0 ||
        done_a !== 1'b0 || error_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: addr=%0d data=%0h valid=%b busy=%b done=%b err=%b, want 0/0/0/0/0/0",
               addr_a, data_a, valid_a, busy_a, done_a, error_a);
    end
    checks++;
    if (addr_b !== 32'(B_START) || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: addr=%0d valid=%b busy=%b, want %0d/0/0", addr_b, valid_b, busy_b, B_START);
    end
  endtask

  task automatic test_continuous;
    int n; bit found; logic [31:0] e;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 260; k++) exp_q.push_back(32'(k % 256));
    enable_a = 1'b1; mode_a = 1'b0; ready_a = 1'b1;
    while (exp_q.size() > 0) begin
      wait_valid_a(10, n, found);
      checks++;
      if (!found) begin errors++; $display("FAIL cont_timeout: no word within 10 cycles"); break; end
      e = exp_q.pop_front();
      checks++;
      if (addr_a !== e || data_a !== rom_f(e)) begin
        errors++;
        $display("FAIL cont_word: addr=%0d data=%0h, want addr=%0d data=%0h", addr_a, data_a, e, rom_f(e));
      end
      checks++;
      if (n != 2) begin errors++; $display("FAIL cont_period: %0d cycles, want 2", n); end
    end
    enable_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int n; bit found;
    do_reset();
    enable_a = 1'b1; mode_a = 1'b0; ready_a = 1'b1;
    do wait_valid_a(10, n, found); while (found && addr_a != 32'd4);
    ready_a = 1'b0;
    checks++;
    if (!found) begin errors++; $display("FAIL bp_reach: word at addr 4 not seen"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1 || addr_a !== 32'd4 || data_a !== rom_f(32'd4)) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b addr=%0d data=%0h, want 1/4/%0h", i, valid_a, addr_a, data_a, rom_f(32'd4));
      end
    end
    ready_a = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || addr_a !== 32'd5) begin
      errors++; $display("FAIL bp_release: valid=%b addr=%0d, want 0/5", valid_a, addr_a);
    end
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || addr_a !== 32'd5 || data_a !== rom_f(32'd5)) begin
      errors++; $display("FAIL bp_next: valid=%b addr=%0d data=%0h, want 1/5/%0h", valid_a, addr_a, data_a, rom_f(32'd5));
    end
    enable_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable_pause;
    int n; bit found;
    do_reset();
    enable_a = 1'b1; mode_a = 1'b0; ready_a = 1'b1;
    do wait_valid_a(10, n, found); while (found && addr_a != 32'd11);
    @(negedge clk);
    checks++;
    if (addr_a !== 32'd12 || busy_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++; $display("FAIL pause_fetch: addr=%0d busy=%b valid=%b, want 12/1/0", addr_a, busy_a, valid_a);
    end
    enable_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (addr_a !== 32'd12 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL pause_idle: addr=%0d busy=%b valid=%b, want 12/0/0", addr_a, busy_a, valid_a);
    end
    enable_a = 1'b1;
    wait_valid_a(10, n, found);
    checks++;
    if (!found || addr_a !== 32'd12 || data_a !== rom_f(32'd12)) begin
      errors++; $display("FAIL pause_resume: found=%b addr=%0d data=%0h, want 1/12/%0h", found, addr_a, data_a, rom_f(32'd12));
    end
    enable_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    int n; bit found;
    do_reset();
    enable_a = 1'b1; mode_a = 1'b0; ready_a = 1'b1;
    do wait_valid_a(10, n, found); while (found && addr_a != 32'd20);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (addr_a !== 32'd0 || valid_a !== 1'b0 || data_a !== 8'd0 || error_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: addr=%0d valid=%b data=%0h err=%b busy=%b, want all 0", addr_a, valid_a, data_a, error_a, busy_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_illegal;
    int n; bit found;
    do_reset();
    ill_addr_a = 32'd7;
    enable_a = 1'b1; mode_a = 1'b0; ready_a = 1'b1;
    do begin
      wait_valid_a(10, n, found);
      if (found && addr_a < 32'd7) begin
        checks++;
        if (error_a !== 1'b0) begin errors++; $display("FAIL ill_early: err=%b at addr %0d, want 0", error_a, addr_a); end
      end
    end while (found && addr_a != 32'd6);
`ifdef ROM_SCAN_HALT_ON_ERR_EN
    wait_valid_a(10, n, found);
    checks++;
    if (found || error_a !== 1'b1 || busy_a !== 1'b0 || addr_a !== 32'd7) begin
      errors++; $display("FAIL ill_halt: valid_seen=%b err=%b busy=%b addr=%0d, want 0/1/0/7", found, error_a, busy_a, addr_a);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    checks++;
    if (error_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++; $display("FAIL ill_stuck: err=%b valid=%b, want 1/0", error_a, valid_a);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (error_a !== 1'b0) begin errors++; $display("FAIL ill_rst: err=%b, want 0", error_a); end
`else
    wait_valid_a(10, n, found);
    checks++;
    if (!found || addr_a !== 32'd7 || data_a !== rom_f(32'd7) || error_a !== 1'b1) begin
      errors++; $display("FAIL ill_word: found=%b addr=%0d data=%0h err=%b, want 1/7/%0h/1", found, addr_a, data_a, error_a, rom_f(32'd7));
    end
    wait_valid_a(10, n, found);
    checks++;
    if (!found || addr_a !== 32'd8 || error_a !== 1'b1) begin
      errors++; $display("FAIL ill_continue: found=%b addr=%0d err=%b, want 1/8/1", found, addr_a, error_a);
    end
    enable_a = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (error_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL ill_clear: err=%b busy=%b, want 0/0", error_a, busy_a);
    end
`endif
  endtask

  task automatic test_oneshot;
    int n; bit found; logic [31:0] e;
    do_reset();
    mode_b = 1'b1; enable_b = 1'b1; ready_b = 1'b1;
    wait_valid_b(6, n, found);
    checks++;
    if (found || busy_b !== 1'b0) begin
      errors++; $display("FAIL os_nostart: valid_seen=%b busy=%b, want 0/0", found, busy_b);
    end
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.delete();
      for (int unsigned a = B_START; a <= B_END; a += B_STEP) exp_q.push_back(32'(a));
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      checks++;
      if (busy_b !== 1'b1 || done_b !== 1'b0) begin
        errors++; $display("FAIL os_launch: busy=%b done=%b, want 1/0", busy_b, done_b);
      end
      wait_valid_b(10, n, found);
      n++;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (!found || addr_b !== e || data_b !== rom_f(e) || n != int'(B_DIV + 1)) begin
          errors++;
          $display("FAIL os_word: found=%b addr=%0d data=%0h gap=%0d, want 1/%0d/%0h/%0d", found, addr_b, data_b, n, e, rom_f(e), B_DIV + 1);
        end
        if (!found) break;
        if (exp_q.size() > 0) wait_valid_b(10, n, found);
      end
      @(negedge clk);
      checks++;
      if (done_b !== 1'b1 || busy_b !== 1'b0 || addr_b !== 32'(B_END) || valid_b !== 1'b0) begin
        errors++; $display("FAIL os_done: done=%b busy=%b addr=%0d valid=%b, want 1/0/%0d/0", done_b, busy_b, addr_b, valid_b, B_END);
      end
      repeat (3) @(negedge clk);
    end
    mode_b = 1'b0;
    @(negedge clk);
    checks++;
    if (done_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL os_to_idle: done=%b busy=%b, want 0/0", done_b, busy_b);
    end
    exp_q.delete();
    e = 32'(B_END);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(e);
      e = (e + B_STEP > B_END) ? 32'(B_START) : e + B_STEP;
    end
    while (exp_q.size() > 0) begin
      wait_valid_b(10, n, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || addr_b !== e || data_b !== rom_f(e)) begin
        errors++; $display("FAIL wrap_b: found=%b addr=%0d data=%0h, want 1/%0d/%0h", found, addr_b, data_b, e, rom_f(e));
        break;
      end
    end
    enable_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_continuous();
    test_backpressure();
    test_enable_pause();
    test_rst_mid();
    test_illegal();
    test_oneshot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_scanner.md
Name: rom_scanner

Overview:
- Parametrised address sequencer that sweeps a configurable region of a combinational ROM (address in; data and illegal flag out).
- Registers each word and presents it on a valid/ready output with backpressure.
- Supports continuous (wrap) and one-shot modes, a per-step prescaler, a configurable stride and sticky illegal-address reporting.
- Successor to the fixed 0..255 free-running ROM test counter; sits between the ROM and an output port or consumer.

Parameters:
ADDR_W, 32, width of o_addr
DATA_W, 8, width of ROM data and o_data
START_ADDR, 0, first address of sweep
END_ADDR, 255, last permitted address (inclusive); must be >= START_ADDR
STEP, 1, address increment per word; must be >= 1
DIV, 1, clk cycles spent in FETCH per word; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
i_enable  input  1  scan permitted
i_mode  input  1  0 = continuous wrap, 1 = one-shot
i_start  input  1  one-cycle pulse; launches one-shot sweep, clears o_error
o_addr  output  ADDR_W  address driven to ROM
i_rom_data  input  DATA_W  ROM read data for o_addr (combinational)
i_rom_illegal  input  1  ROM flags o_addr out of range
o_data  output  DATA_W  registered ROM word
o_valid  output  1  o_data valid
i_ready  input  1  consumer accepts o_data when o_valid && i_ready
o_busy  output  1  high in FETCH and HOLD
o_done  output  1  one-shot sweep complete
o_error  output  1  sticky: an illegal address was captured

Behaviour:
- Reset values: state IDLE, o_addr = START_ADDR, o_data = 0, o_valid = 0, o_busy = 0, o_done = 0, o_error = 0, prescale counter = 0.
- IDLE:
  - i_enable && i_mode==0 -> FETCH.
  - i_enable && i_mode==1 && i_start -> FETCH; o_addr = START_ADDR; o_error cleared.
  - i_start in continuous mode only clears o_error.
- FETCH:
  - Prescale counter increments each cycle.
  - When count == DIV-1: o_data <= i_rom_data, o_valid <= 1, counter <= 0, -> HOLD.
  - If i_rom_illegal is high in that same capture cycle, o_error <= 1.
  - i_enable low in FETCH -> IDLE; counter cleared; o_addr retained so the scan resumes at the same address.
- HOLD:
  - o_valid stays high and o_data stays stable until the handshake; never withdrawn, including if i_enable falls.
  - On o_valid && i_ready: o_valid <= 0, then compute next = o_addr + STEP in ADDR_W+1 bits.
    - next > END_ADDR, continuous: o_addr = START_ADDR.
    - next > END_ADDR, one-shot: -> DONE, o_done = 1.
    - Otherwise: o_addr = next.
  - After the address update: i_enable high -> FETCH, else IDLE.
- DONE:
  - o_done held high, o_busy = 0.
  - i_start && i_enable -> FETCH from START_ADDR; o_done and o_error cleared.
  - Switching i_mode to 0 -> IDLE; o_done cleared.
- Throughput: DIV=1 with i_ready tied high gives one word every 2 cycles (FETCH + HOLD). In general the period is DIV+1 cycles.
- Latency: o_data captures the ROM output for the current o_addr exactly DIV cycles after FETCH entry.
- i_start outside IDLE/DONE is ignored.
- rst at any cycle forces the reset values on the next edge, including mid-handshake; the pending word is lost.

Optional Feature:
- ROM_SCAN_HALT_ON_ERR_EN defined:
  - An illegal capture enters the ERROR state.
  - o_valid is not asserted; o_data holds its previous value.
  - o_error = 1, o_busy = 0.
  - ERROR is exited only by rst.
- Not defined:
  - o_error is set (sticky) and o_data = i_rom_data unchanged.
  - o_valid asserts normally and scanning continues.

Test Plan:
- Defaults, mode 0, enable=1, ready=1 -> o_addr sequence 0,1,…,255,0,1; o_valid pulses every 2nd cycle; each o_data equals the ROM model at that address.
- START=0, END=10, STEP=3, mode 1, start pulse -> four words at 0,3,6,9; then o_done=1, o_busy=0, o_addr=9.
- ready held low 5 cycles during HOLD at addr 4 -> o_valid=1 and o_data stable for all 5 cycles, o_addr=4; next word at addr 5 follows 2 cycles after ready rises.
- DIV=4, ready=1 -> o_valid period 5 cycles; capture occurs 4 cycles after FETCH entry.
- ROM illegal at addr 7 -> o_error=1 after capture. Without the macro, scanning continues to 8. With ROM_SCAN_HALT_ON_ERR_EN, o_valid stays 0 and o_busy=0 until rst.
- rst asserted while o_valid=1 at addr 20 -> next cycle o_addr=0, o_valid=0, o_data=0, o_error=0, state IDLE; enable deasserted mid-FETCH at addr 12 -> re-enable resumes at 12.
